char_row_buf: RTL and testbench
===============================

# char_row_buf

Parametrised single-row character buffer for the VGA text path. It holds one row of character codes and accepts writes by explicit column or through an auto-incrementing cursor. It clears itself with a sequenced clear engine, and serves pixel-coordinate lookups through a two-stage pipeline. It sits between the host command decoder (write side) and the glyph ROM / pixel serialiser (read side).

## Interface
- COLS, 80: characters per row; 2..1024.
- CHAR_W, 6: character code width.
- CELL_W, 8: pixels per character cell; power of two, 2..32.
- ROW_H, 16: scanlines per row; power of two, 2..64.
- Y_START, 0: first scanline of the row.
- BLANK, 0: code returned outside the row and written by clear.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write wr_char at wr_col
- wr_col  in  COL_W=$clog2(COLS)  column for wr_en / cur_set
- wr_char  in  CHAR_W  write data
- wr_push  in  1  write wr_char at cursor, advance cursor
- cur_set  in  1  load cursor from wr_col
- clr_req  in  1  start a clear of all columns
- busy  out  1  clear engine running
- wr_drop  out  1  one-cycle pulse: previous-cycle write rejected
- cursor  out  COL_W  current cursor column
- xcoor  in  10  pixel x
- ycoor  in  9  pixel y
- char_out  out  CHAR_W  character at (xcoor, ycoor), or BLANK
- glyph_row  out  $clog2(ROW_H)  ycoor - Y_START, 0 on miss
- glyph_col  out  $clog2(CELL_W)  xcoor mod CELL_W, 0 on miss
- hit  out  1  coordinate lies inside the row

## Operation
- Storage: COLS x CHAR_W flop array. Contents are not reset. After reset, the clear engine initialises them.
- Clear FSM has two states, IDLE and CLEAR.
  - Reset forces CLEAR with clr_col = 0 and cursor = 0.
  - In CLEAR, each cycle writes BLANK to clr_col and increments it. At clr_col = COLS-1 it writes, then goes to IDLE.
  - clr_req in IDLE enters CLEAR at clr_col = 0 and sets cursor = 0.
  - clr_req in CLEAR restarts from column 0.
  - busy = (state == CLEAR).
- Write priority, highest first: clear engine > wr_en > wr_push. cur_set is independent.
- A write is rejected, and wr_drop pulses on the next cycle, in any of these cases:
  - wr_en or wr_push while busy;
  - wr_en with wr_col >= COLS;
  - wr_push in the same cycle as wr_en. wr_en is performed and the cursor is not advanced.
- wr_push: writes at cursor. Cursor increments, and wraps from COLS-1 to 0.
- cur_set: cursor <= wr_col when wr_col < COLS, otherwise ignored with no wr_drop. When cur_set and wr_push coincide, the push uses the old cursor and the cursor is then loaded from wr_col.
- Read, stage 1:
  - col = xcoor >> log2(CELL_W);
  - in_y = (ycoor >= Y_START) && (ycoor < Y_START+ROW_H);
  - register col, in_y && (col < COLS), the row offset and glyph_col.
- Read, stage 2:
  - register char_out = array[col] on hit, BLANK otherwise;
  - glyph_row and glyph_col are zeroed on miss.
  - Comparisons use 11-bit unsigned arithmetic so that Y_START+ROW_H never wraps.
- Array is read-first: a stage-2 read and a write to the same column at the same edge return the old value.

## Timing
- Read latency: coordinates sampled at edge N produce char_out, hit, glyph_row and glyph_col valid after edge N+2. Throughput is one lookup per cycle, with no stall.
- A write at edge N is visible to a stage-2 read at edge N+1 or later.
- A clear takes exactly COLS cycles. busy falls after the edge that writes column COLS-1.
- wr_drop is registered: a rejected write at edge N produces wr_drop high for the cycle after edge N.
- Reset values: char_out = BLANK, hit = 0, glyph_row = 0, glyph_col = 0, wr_drop = 0, cursor = 0, busy = 1.
- Reset asserted mid-clear or mid-read flushes the pipeline and restarts the clear at column 0.

## Configuration
- CHAR_ROW_CURSOR_EN defined:
  - cursor logic is present;
  - wr_push and cur_set behave as described.
- CHAR_ROW_CURSOR_EN undefined:
  - no cursor register;
  - cursor output tied to 0;
  - wr_push and cur_set ignored, and do not cause wr_drop.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then wait: busy = 1 for exactly 80 cycles after release. Afterwards, a read at (0, 5) gives char_out = 0 and hit = 1 two cycles later.
- Write 6'b101010 at col 0, then read (x = 3, y = 5):
  - char_out = 101010, glyph_row = 5, glyph_col = 3, hit = 1 at N+2;
  - the same x with y = 15 still hits (ROW_H = 16);
  - y = 16 gives BLANK and hit = 0.
- Write col 79 = 6'h11 and read x = 639: char_out = 6'h11. x = 640 (col 80) gives hit = 0 and BLANK.
- Cursor build, with cur_set col 78 followed by three wr_push of 1, 2, 3:
  - cols 78 and 79 hold 1 and 2, col 0 holds 3;
  - cursor = 1.
  - wr_en at col 5 plus wr_push in the same cycle: col 5 is written, the cursor is unchanged and wr_drop pulses once.
- clr_req, then wr_en in the next cycle:
  - the write is dropped and wr_drop pulses;
  - a second clr_req 10 cycles in extends busy to 90 cycles total;
  - all columns read BLANK afterwards.
- Same-edge hazard: hold a read on col 2 (x = 16) while writing col 2 = 6'h3F.
  - char_out shows the old value at the collision edge and 6'h3F from the next sample onward.
  - wr_col = 90 produces wr_drop and leaves the array unchanged.

Source files
------------

// File: rtl/char_row_buf.sv
// char_row_buf: one row of character codes for the VGA text path, with column/cursor
// writes, a sequenced clear engine and a two-stage pixel lookup. Optional cursor: CHAR_ROW_CURSOR_EN.

module char_row_buf #(
  parameter int COLS = 80,
  parameter int CHAR_W = 6,
  parameter int CELL_W = 8,
  parameter int ROW_H = 16,
  parameter int Y_START = 0,
  parameter logic [CHAR_W-1:0] BLANK = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(COLS)-1:0]    wr_col,
  input  logic [CHAR_W-1:0]          wr_char,
  input  logic                       wr_push,
  input  logic                       cur_set,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       wr_drop,
  output logic [$clog2(COLS)-1:0]    cursor,
  input  logic [9:0]                 xcoor,
  input  logic [8:0]                 ycoor,
  output logic [CHAR_W-1:0]          char_out,
  output logic [$clog2(ROW_H)-1:0]   glyph_row,
  output logic [$clog2(CELL_W)-1:0]  glyph_col,
  output logic                       hit,
  output logic                       dbg_state
);

  localparam int COL_W = $clog2(COLS);
  localparam int CW_W  = $clog2(CELL_W);
  localparam int RH_W  = $clog2(ROW_H);
  localparam logic [10:0]      COLS_X   = 11'(COLS);
  localparam logic [10:0]      Y_LO     = 11'(Y_START);
  localparam logic [10:0]      Y_HI     = 11'(Y_START + ROW_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [COL_W-1:0] r_clr_col;
  logic [COL_W-1:0] w_clr_col_nxt;

  logic [CHAR_W-1:0] r_mem [COLS];

  logic              w_busy;
  logic              w_push;
  logic              w_col_ok;
  logic              w_we;
  logic [COL_W-1:0]  w_waddr;
  logic [CHAR_W-1:0] w_wdata;
  logic              w_drop;
  logic              w_push_ok;
  logic [COL_W-1:0]  w_cur;
  logic              r_drop;

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_col <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_col <= w_clr_col_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_col_nxt = r_clr_col;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_col_nxt = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_req) begin
          w_clr_col_nxt = '0;
        end else if (r_clr_col == COL_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_clr_col_nxt = '0;
        end else begin
          w_clr_col_nxt = r_clr_col + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_col_nxt = '0;
      end
    endcase
  end

  assign w_busy    = (r_state == ST_CLEAR);
  assign busy      = w_busy;
  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Write port. There is no backpressure: a write request is a single-cycle
  // strobe that either lands at the next edge or is discarded, and a discarded
  // strobe is reported by wr_drop in the following cycle. The clear engine owns
  // the array while busy; wr_en beats wr_push when both arrive together.
  // ---------------------------------------------------------------------------
  assign w_col_ok = (11'(wr_col) < COLS_X);

  always_comb begin
    w_we      = 1'b0;
    w_waddr   = r_clr_col;
    w_wdata   = BLANK;
    w_drop    = 1'b0;
    w_push_ok = 1'b0;
    if (w_busy) begin
      w_we   = 1'b1;
      w_drop = wr_en | w_push;
    end else if (wr_en) begin
      w_drop = ~w_col_ok | w_push;
      if (w_col_ok) begin
        w_we    = 1'b1;
        w_waddr = wr_col;
        w_wdata = wr_char;
      end
    end else if (w_push) begin
      w_we      = 1'b1;
      w_waddr   = w_cur;
      w_wdata   = wr_char;
      w_push_ok = 1'b1;
    end
  end

  // Storage is deliberately unreset; the clear engine initialises it.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_drop;
    end
  end

  assign wr_drop = r_drop;

  // ---------------------------------------------------------------------------
  // Cursor
  // ---------------------------------------------------------------------------
`ifdef CHAR_ROW_CURSOR_EN
  logic [COL_W-1:0] r_cursor;

  assign w_push = wr_push;

  // A coincident cur_set wins over the push advance; the push already used the old cursor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cursor <= '0;
    end else if (clr_req) begin
      r_cursor <= '0;
    end else if (cur_set && w_col_ok) begin
      r_cursor <= wr_col;
    end else if (w_push_ok) begin
      r_cursor <= (r_cursor == COL_LAST) ? '0 : r_cursor + 1'b1;
    end
  end

  assign w_cur  = r_cursor;
  assign cursor = r_cursor;
`else
  logic w_unused_cursor;

  assign w_push          = 1'b0;
  assign w_cur           = '0;
  assign cursor          = '0;
  assign w_unused_cursor = wr_push ^ cur_set ^ w_push_ok;
`endif

  // ---------------------------------------------------------------------------
  // Lookup pipeline, stage 1: decode the pixel coordinate.
  // ---------------------------------------------------------------------------
  logic [9:0]       w_col_x;
  logic             w_in_y;
  logic             w_s1_hit;
  logic [RH_W-1:0]  w_row;

  logic [COL_W-1:0] r_s1_col;
  logic             r_s1_hit;
  logic [RH_W-1:0]  r_s1_row;
  logic [CW_W-1:0]  r_s1_gcol;

  assign w_col_x  = xcoor >> CW_W;
  assign w_in_y   = (11'(ycoor) >= Y_LO) && (11'(ycoor) < Y_HI);
  assign w_s1_hit = w_in_y && (11'(w_col_x) < COLS_X);
  assign w_row    = RH_W'(11'(ycoor) - Y_LO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_col  <= '0;
      r_s1_hit  <= 1'b0;
      r_s1_row  <= '0;
      r_s1_gcol <= '0;
    end else begin
      r_s1_col  <= w_col_x[COL_W-1:0];
      r_s1_hit  <= w_s1_hit;
      r_s1_row  <= w_row;
      r_s1_gcol <= xcoor[CW_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: array read (old data on a same-edge write) and miss blanking.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_out  <= BLANK;
      hit       <= 1'b0;
      glyph_row <= '0;
      glyph_col <= '0;
    end else begin
      hit <= r_s1_hit;
      if (r_s1_hit) begin
        char_out  <= r_mem[r_s1_col];
        glyph_row <= r_s1_row;
        glyph_col <= r_s1_gcol;
      end else begin
        char_out  <= BLANK;
        glyph_row <= '0;
        glyph_col <= '0;
      end
    end
  end

endmodule

// File: tb/tb_char_row_buf.sv
// tb_char_row_buf: directed bench for char_row_buf (80 cols, 6-bit codes, 8x16 cells),
// covering clear timing, lookups, boundaries, drops, cursor behaviour and the read/write hazard.

module tb_char_row_buf;

  localparam int COLS   = 80;
  localparam int CHAR_W = 6;
  localparam int COL_W  = 7;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [COL_W-1:0]  wr_col;
  logic [CHAR_W-1:0] wr_char;
  logic              wr_push;
  logic              cur_set;
  logic              clr_req;
  logic              busy;
  logic              wr_drop;
  logic [COL_W-1:0]  cursor;
  logic [9:0]        xcoor;
  logic [8:0]        ycoor;
  logic [CHAR_W-1:0] char_out;
  logic [3:0]        glyph_row;
  logic [2:0]        glyph_col;
  logic              hit;
  logic              dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [CHAR_W-1:0] exp_q[$];

  char_row_buf #(
    .COLS(COLS), .CHAR_W(CHAR_W), .CELL_W(8), .ROW_H(16), .Y_START(0), .BLANK('0)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_col(wr_col), .wr_char(wr_char),
    .wr_push(wr_push), .cur_set(cur_set), .clr_req(clr_req), .busy(busy),
    .wr_drop(wr_drop), .cursor(cursor), .xcoor(xcoor), .ycoor(ycoor),
    .char_out(char_out), .glyph_row(glyph_row), .glyph_col(glyph_col),
    .hit(hit), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-cycle write strobe on the write port, leaving all strobes low afterwards
  task automatic drive_wr(input logic en, input logic push, input logic set,
                          input logic [COL_W-1:0] col, input logic [CHAR_W-1:0] ch);
    wr_en   = en;
    wr_push = push;
    cur_set = set;
    wr_col  = col;
    wr_char = ch;
    tick();
    wr_en   = 1'b0;
    wr_push = 1'b0;
    cur_set = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [9:0] x, input logic [8:0] y,
                          input logic [CHAR_W-1:0] e_char, input logic e_hit,
                          input logic [3:0] e_row, input logic [2:0] e_gcol);
    exp_q.push_back(e_char);
    xcoor = x;
    ycoor = y;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq({tag, "_char"}, 32'(char_out), 32'(exp_q.pop_front()));
    check_eq({tag, "_hit"}, 32'(hit), 32'(e_hit));
    check_eq({tag, "_row"}, 32'(glyph_row), 32'(e_row));
    check_eq({tag, "_gcol"}, 32'(glyph_col), 32'(e_gcol));
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_push = 1'b0;
    cur_set = 1'b0;
    clr_req = 1'b0;
    wr_col  = '0;
    wr_char = '0;
    xcoor   = '0;
    ycoor   = '0;
    repeat (3) @(posedge clk);
    #1;

    // reset values
    check_eq("rst_char", 32'(char_out), 0);
    check_eq("rst_hit", 32'(hit), 0);
    check_eq("rst_row", 32'(glyph_row), 0);
    check_eq("rst_gcol", 32'(glyph_col), 0);
    check_eq("rst_drop", 32'(wr_drop), 0);
    check_eq("rst_cursor", 32'(cursor), 0);
    check_eq("rst_busy", 32'(busy), 1);
    check_eq("rst_state", 32'(dbg_state), 1);

    // power-up clear lasts exactly COLS cycles
    rst = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check_eq("init_busy_len", n, 80);
    check_eq("idle_state", 32'(dbg_state), 0);

    read_chk("rd_blank0", 10'd0, 9'd5, 6'h00, 1'b1, 4'd5, 3'd0);

    // basic write + lookups, y boundaries
    drive_wr(1'b1, 1'b0, 1'b0, 7'd0, 6'b101010);
    check_eq("wr0_drop", 32'(wr_drop), 0);
    read_chk("rd_c0_y5", 10'd3, 9'd5, 6'b101010, 1'b1, 4'd5, 3'd3);
    read_chk("rd_c0_y15", 10'd3, 9'd15, 6'b101010, 1'b1, 4'd15, 3'd3);
    read_chk("rd_c0_y16", 10'd3, 9'd16, 6'h00, 1'b0, 4'd0, 3'd0);

    // x boundaries
    drive_wr(1'b1, 1'b0, 1'b0, 7'd79, 6'h11);
    read_chk("rd_x639", 10'd639, 9'd0, 6'h11, 1'b1, 4'd0, 3'd7);
    read_chk("rd_x640", 10'd640, 9'd2, 6'h00, 1'b0, 4'd0, 3'd0);

    // out-of-range column is dropped, pulse lasts one cycle
    drive_wr(1'b1, 1'b0, 1'b0, 7'd90, 6'h15);
    check_eq("bad_col_drop", 32'(wr_drop), 1);
    tick();
    check_eq("bad_col_drop_end", 32'(wr_drop), 0);
    read_chk("rd_after_bad", 10'd0, 9'd1, 6'b101010, 1'b1, 4'd1, 3'd0);

    // same-edge read/write on col 2
    xcoor = 10'd16;
    ycoor = 9'd0;
    tick();
    wr_en   = 1'b1;
    wr_col  = 7'd2;
    wr_char = 6'h3F;
    tick();
    wr_en = 1'b0;
    check_eq("hazard_old", 32'(char_out), 32'(6'h00));
    tick();
    check_eq("hazard_new", 32'(char_out), 32'(6'h3F));
    check_eq("hazard_hit", 32'(hit), 1);

`ifdef CHAR_ROW_CURSOR_EN
    drive_wr(1'b0, 1'b0, 1'b1, 7'd78, 6'h00);
    check_eq("cur_set78", 32'(cursor), 78);
    drive_wr(1'b0, 1'b1, 1'b0, 7'd0, 6'h01);
    drive_wr(1'b0, 1'b1, 1'b0, 7'd0, 6'h02);
    drive_wr(1'b0, 1'b1, 1'b0, 7'd0, 6'h03);
    check_eq("push_drop", 32'(wr_drop), 0);
    check_eq("cur_wrap", 32'(cursor), 1);
    read_chk("rd_c78", 10'd624, 9'd0, 6'h01, 1'b1, 4'd0, 3'd0);
    read_chk("rd_c79", 10'd632, 9'd0, 6'h02, 1'b1, 4'd0, 3'd0);
    read_chk("rd_c0p", 10'd0, 9'd0, 6'h03, 1'b1, 4'd0, 3'd0);
    drive_wr(1'b1, 1'b1, 1'b0, 7'd5, 6'h07);
    check_eq("collide_drop", 32'(wr_drop), 1);
    check_eq("collide_cursor", 32'(cursor), 1);
    tick();
    check_eq("collide_drop_end", 32'(wr_drop), 0);
    read_chk("rd_c5", 10'd40, 9'd0, 6'h07, 1'b1, 4'd0, 3'd0);
    read_chk("rd_c1", 10'd8, 9'd0, 6'h00, 1'b1, 4'd0, 3'd0);
`else
    drive_wr(1'b0, 1'b0, 1'b1, 7'd78, 6'h00);
    check_eq("nocur_set", 32'(cursor), 0);
    drive_wr(1'b0, 1'b1, 1'b0, 7'd0, 6'h01);
    check_eq("nocur_push_drop", 32'(wr_drop), 0);
    check_eq("nocur_cursor", 32'(cursor), 0);
    read_chk("rd_nocur_c0", 10'd0, 9'd0, 6'b101010, 1'b1, 4'd0, 3'd0);
    drive_wr(1'b1, 1'b1, 1'b0, 7'd5, 6'h07);
    check_eq("nocur_collide_drop", 32'(wr_drop), 0);
    read_chk("rd_c5", 10'd40, 9'd0, 6'h07, 1'b1, 4'd0, 3'd0);
`endif

    // clear request, write during clear, restart at 10 cycles
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    check_eq("clr_busy", 32'(busy), 1);
    check_eq("clr_cursor", 32'(cursor), 0);
    wr_en   = 1'b1;
    wr_col  = 7'd10;
    wr_char = 6'h1F;
    tick();
    n++;
    wr_en = 1'b0;
    check_eq("clr_wr_drop", 32'(wr_drop), 1);
    while (n < 9) begin
      tick();
      n++;
    end
    check_eq("clr_drop_end", 32'(wr_drop), 0);
    clr_req = 1'b1;
    tick();
    n++;
    clr_req = 1'b0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check_eq("clr_busy_len", n, 90);

    for (int c = 0; c < COLS; c++) begin
      read_chk($sformatf("blank_c%0d", c), 10'(c * 8), 9'd4, 6'h00, 1'b1, 4'd4, 3'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
